// File: rtl/spi_fl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_fl_pkg : opcodes, FSM encoding and command decode for the        |
// |              flash-style SPI responder. Quad read needs SPI_SL_QUAD_EN|
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package spi_fl_pkg;

    localparam logic [7:0] c_op_read       = 8'h03;
    localparam logic [7:0] c_op_fast_read  = 8'h0B;
    localparam logic [7:0] c_op_page_prog  = 8'h02;
    localparam logic [7:0] c_op_read_id    = 8'h9F;
    localparam logic [7:0] c_op_read_sr    = 8'h05;
    localparam logic [7:0] c_op_quad_read  = 8'h6B;

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_cmd      = 3'd1;
    localparam logic [2:0] c_st_addr     = 3'd2;
    localparam logic [2:0] c_st_dummy    = 3'd3;
    localparam logic [2:0] c_st_data_in  = 3'd4;
    localparam logic [2:0] c_st_data_out = 3'd5;

    typedef struct packed {
        logic       has_addr;
        logic [7:0] dummy_cnt;
        logic       is_out;
        logic       is_quad;
    } cmd_info_t;

    // Unknown opcodes fall through to a plain receive frame.
    function automatic cmd_info_t decode_cmd(input logic [7:0] op, input logic [7:0] fast_dummy);
        cmd_info_t info;
        info = '{has_addr: 1'b0, dummy_cnt: 8'd0, is_out: 1'b0, is_quad: 1'b0};
        case (op)
            c_op_read:      begin info.has_addr = 1'b1; info.is_out = 1'b1; end
            c_op_fast_read: begin info.has_addr = 1'b1; info.is_out = 1'b1; info.dummy_cnt = fast_dummy; end
            c_op_page_prog: begin info.has_addr = 1'b1; end
            c_op_read_id:   begin info.is_out = 1'b1; end
            c_op_read_sr:   begin info.is_out = 1'b1; end
`ifdef SPI_SL_QUAD_EN
            c_op_quad_read: begin
                info.has_addr  = 1'b1;
                info.is_out    = 1'b1;
                info.is_quad   = 1'b1;
                info.dummy_cnt = fast_dummy;
            end
`endif
            default: ;
        endcase
        return info;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sl_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_sl_sync : synchronizers for sclk/ss/mosi plus edge detectors.    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module spi_sl_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sclk,
    input  logic i_ss,
    input  logic i_mosi,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_ss_rise,
    output logic o_ss_fall,
    output logic o_mosi
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_ss_prev;

    // ss resets to "selected" so a frame already in flight at reset release
    // only becomes visible again after ss has gone high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_ss_prev   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_ss_prev   <= r_ss_sync[SYNC_STAGES-1];
        end
    end

    assign o_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
    assign o_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_prev;
    assign o_ss_rise   = r_ss_sync[SYNC_STAGES-1] & ~r_ss_prev;
    assign o_ss_fall   = ~r_ss_sync[SYNC_STAGES-1] & r_ss_prev;
    assign o_mosi      = r_mosi_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave_fl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_slave_fl : SPI mode-0 flash-style responder (cmd/addr/dummy/data)|
// |                Define SPI_SL_QUAD_EN for quad read (0x6B, dq ports). |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module spi_slave_fl
    import spi_fl_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int SYNC_STAGES = 2,
    parameter int FAST_DUMMY  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [7:0]        cmd,
    output logic              cmd_valid,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    output logic              tx_req,
    input  logic [7:0]        tx_data,
    output logic              frame_end,
    output logic              busy
`ifdef SPI_SL_QUAD_EN
    ,
    output logic [3:0]        dq_out,
    output logic [3:0]        dq_oe
`endif
);

    localparam int                 c_cnt_w        = $clog2(ADDR_W) + 8;
    localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_byte_end = c_cnt_w'(7);
    localparam logic [c_cnt_w-1:0] c_cnt_addr_end = c_cnt_w'(ADDR_W - 1);

    logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall, w_mosi;

    spi_sl_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_sclk      (sclk),
        .i_ss        (ss),
        .i_mosi      (mosi),
        .o_sclk_rise (w_sclk_rise),
        .o_sclk_fall (w_sclk_fall),
        .o_ss_rise   (w_ss_rise),
        .o_ss_fall   (w_ss_fall),
        .o_mosi      (w_mosi)
    );

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [7:0]         r_shift;
    logic [7:0]         r_tx_sh;
    logic [ADDR_W-1:0]  r_addr_sh;
    cmd_info_t          r_info;
    logic [7:0]         r_cmd, r_rx_data;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_cmd_valid, r_addr_valid, r_rx_valid, r_tx_req, r_frame_end;
    logic               r_in_frame, r_miso, r_miso_oe, r_quad, r_load_pending;
    logic [3:0]         r_dq;

    logic [7:0]         w_cmd_byte;
    logic [ADDR_W-1:0]  w_addr_word;
    cmd_info_t          w_info_new;
    logic [c_cnt_w-1:0] w_dummy_end;
    logic [c_cnt_w-1:0] w_out_end;

    assign w_cmd_byte  = {r_shift[6:0], w_mosi};
    assign w_addr_word = {r_addr_sh[ADDR_W-2:0], w_mosi};
    assign w_info_new  = decode_cmd(w_cmd_byte, 8'(FAST_DUMMY));
    assign w_dummy_end = c_cnt_w'(r_info.dummy_cnt) - c_cnt_one;
    assign w_out_end   = r_quad ? c_cnt_one : c_cnt_byte_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_st_idle;
            r_cnt          <= '0;
            r_shift        <= '0;
            r_tx_sh        <= '0;
            r_addr_sh      <= '0;
            r_info         <= '0;
            r_cmd          <= '0;
            r_rx_data      <= '0;
            r_addr         <= '0;
            r_cmd_valid    <= 1'b0;
            r_addr_valid   <= 1'b0;
            r_rx_valid     <= 1'b0;
            r_tx_req       <= 1'b0;
            r_frame_end    <= 1'b0;
            r_in_frame     <= 1'b0;
            r_miso         <= 1'b0;
            r_miso_oe      <= 1'b0;
            r_quad         <= 1'b0;
            r_load_pending <= 1'b0;
            r_dq           <= '0;
        end else begin
            r_cmd_valid  <= 1'b0;
            r_addr_valid <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_tx_req     <= 1'b0;
            r_frame_end  <= 1'b0;
            // ss rising takes priority over any sclk edge seen in the same cycle.
            if (w_ss_rise) begin
                r_state        <= c_st_idle;
                r_frame_end    <= r_in_frame;
                r_in_frame     <= 1'b0;
                r_miso_oe      <= 1'b0;
                r_quad         <= 1'b0;
                r_miso         <= 1'b0;
                r_dq           <= '0;
                r_load_pending <= 1'b0;
            end else if (w_ss_fall) begin
                r_state        <= c_st_cmd;
                r_in_frame     <= 1'b1;
                r_cnt          <= '0;
                r_shift        <= '0;
                r_load_pending <= 1'b0;
            end else begin
                case (r_state)
                    c_st_cmd: if (w_sclk_rise) begin
                        r_shift <= w_cmd_byte;
                        r_cnt   <= r_cnt + c_cnt_one;
                        if (r_cnt == c_cnt_byte_end) begin
                            r_cmd       <= w_cmd_byte;
                            r_cmd_valid <= 1'b1;
                            r_info      <= w_info_new;
                            r_cnt       <= '0;
                            if (w_info_new.has_addr) begin
                                r_state <= c_st_addr;
                            end else if (w_info_new.is_out) begin
                                r_state        <= c_st_data_out;
                                r_tx_req       <= 1'b1;
                                r_load_pending <= 1'b1;
                                r_miso_oe      <= 1'b1;
                                r_quad         <= w_info_new.is_quad;
                            end else begin
                                r_state <= c_st_data_in;
                            end
                        end
                    end
                    c_st_addr: if (w_sclk_rise) begin
                        r_addr_sh <= w_addr_word;
                        r_cnt     <= r_cnt + c_cnt_one;
                        if (r_cnt == c_cnt_addr_end) begin
                            r_addr       <= w_addr_word;
                            r_addr_valid <= 1'b1;
                            r_cnt        <= '0;
                            if (r_info.dummy_cnt != 8'd0) begin
                                r_state <= c_st_dummy;
                            end else if (r_info.is_out) begin
                                r_state        <= c_st_data_out;
                                r_tx_req       <= 1'b1;
                                r_load_pending <= 1'b1;
                                r_miso_oe      <= 1'b1;
                                r_quad         <= r_info.is_quad;
                            end else begin
                                r_state <= c_st_data_in;
                            end
                        end
                    end
                    c_st_dummy: if (w_sclk_rise) begin
                        r_cnt <= r_cnt + c_cnt_one;
                        if (r_cnt == w_dummy_end) begin
                            r_cnt <= '0;
                            if (r_info.is_out) begin
                                r_state        <= c_st_data_out;
                                r_tx_req       <= 1'b1;
                                r_load_pending <= 1'b1;
                                r_miso_oe      <= 1'b1;
                                r_quad         <= r_info.is_quad;
                            end else begin
                                r_state <= c_st_data_in;
                            end
                        end
                    end
                    c_st_data_in: if (w_sclk_rise) begin
                        r_shift <= w_cmd_byte;
                        r_cnt   <= r_cnt + c_cnt_one;
                        if (r_cnt == c_cnt_byte_end) begin
                            r_rx_data  <= w_cmd_byte;
                            r_rx_valid <= 1'b1;
                            r_cnt      <= '0;
                        end
                    end
                    c_st_data_out: begin
                        if (w_sclk_rise) begin
                            if (r_cnt == w_out_end) begin
                                r_cnt          <= '0;
                                r_tx_req       <= 1'b1;
                                r_load_pending <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + c_cnt_one;
                            end
                        end else if (w_sclk_fall) begin
                            // A pending request means this edge starts a fresh byte.
                            if (r_load_pending) begin
                                r_load_pending <= 1'b0;
                                if (r_quad) begin
                                    r_dq    <= tx_data[7:4];
                                    r_tx_sh <= {tx_data[3:0], 4'b0000};
                                end else begin
                                    r_miso  <= tx_data[7];
                                    r_tx_sh <= {tx_data[6:0], 1'b0};
                                end
                            end else if (r_quad) begin
                                r_dq    <= r_tx_sh[7:4];
                                r_tx_sh <= {r_tx_sh[3:0], 4'b0000};
                            end else begin
                                r_miso  <= r_tx_sh[7];
                                r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                            end
                        end
                    end
                    default: r_state <= c_st_idle;
                endcase
            end
        end
    end

    assign miso       = r_quad ? r_dq[1] : r_miso;
    assign miso_oe    = r_miso_oe;
    assign cmd        = r_cmd;
    assign cmd_valid  = r_cmd_valid;
    assign addr       = r_addr;
    assign addr_valid = r_addr_valid;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign tx_req     = r_tx_req;
    assign frame_end  = r_frame_end;
    assign busy       = r_in_frame;
`ifdef SPI_SL_QUAD_EN
    assign dq_out     = r_dq;
    assign dq_oe      = {4{r_quad}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_fl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_slave_fl : scoreboard bench for spi_slave_fl (SPI_SL_QUAD_EN  |
// |                   adds the quad read frame).                         |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_spi_slave_fl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        ss = 1'b1;
    logic        mosi = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        miso, miso_oe, cmd_valid, addr_valid, rx_valid, tx_req, frame_end, busy;
    logic [7:0]  cmd, rx_data;
    logic [23:0] addr;
`ifdef SPI_SL_QUAD_EN
    logic [3:0]  dq_out, dq_oe;
`endif

    spi_slave_fl #(
        .ADDR_W      (24),
        .SYNC_STAGES (2),
        .FAST_DUMMY  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .ss         (ss),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .addr       (addr),
        .addr_valid (addr_valid),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_req     (tx_req),
        .tx_data    (tx_data),
        .frame_end  (frame_end),
        .busy       (busy)
`ifdef SPI_SL_QUAD_EN
        ,
        .dq_out     (dq_out),
        .dq_oe      (dq_oe)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          edge_cnt = 0;
    int          mon_bits = 0;
    logic [7:0]  mon_byte = 8'h00;
    bit          oe_seen = 1'b0;

    logic [7:0]  q_cmd[$];
    logic [23:0] q_addr[$];
    logic [7:0]  q_rx[$];
    logic [7:0]  q_tx[$];
    logic [7:0]  q_miso[$];
    int          q_txreq[$];
    int          q_fe[$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void unexpected(string name, logic [63:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got 0x%0h with nothing expected", name, act);
    endfunction

    // Monitor for the clk-domain pulses; also serves tx_data on request.
    always @(negedge clk) begin
        if (cmd_valid) begin
            if (q_cmd.size() == 0) unexpected("cmd_valid", 64'(cmd));
            else check("cmd", 64'(cmd), 64'(q_cmd.pop_front()));
        end
        if (addr_valid) begin
            if (q_addr.size() == 0) unexpected("addr_valid", 64'(addr));
            else check("addr", 64'(addr), 64'(q_addr.pop_front()));
        end
        if (rx_valid) begin
            if (q_rx.size() == 0) unexpected("rx_valid", 64'(rx_data));
            else check("rx_data", 64'(rx_data), 64'(q_rx.pop_front()));
        end
        if (tx_req) begin
            if (q_txreq.size() == 0) unexpected("tx_req edge", 64'(edge_cnt));
            else check("tx_req edge", 64'(edge_cnt), 64'(q_txreq.pop_front()));
            tx_data = (q_tx.size() != 0) ? q_tx.pop_front() : 8'h00;
        end
        if (frame_end) begin
            if (q_fe.size() == 0) unexpected("frame_end", 64'(edge_cnt));
            else void'(q_fe.pop_front());
        end
        if (miso_oe) oe_seen = 1'b1;
    end

    // Master-side sampling of serial data on each rising sclk.
    always @(posedge sclk) begin
`ifdef SPI_SL_QUAD_EN
        if (dq_oe == 4'hF) begin
            mon_byte = {mon_byte[3:0], dq_out};
            mon_bits += 4;
        end else
`endif
        if (miso_oe) begin
            mon_byte = {mon_byte[6:0], miso};
            mon_bits += 1;
        end
        if (mon_bits == 8) begin
            mon_bits = 0;
            if (q_miso.size() == 0) unexpected("miso byte", 64'(mon_byte));
            else check("miso byte", 64'(mon_byte), 64'(q_miso.pop_front()));
        end
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer_bit(input logic b);
        mosi = b;
        clk_wait(8);
        sclk = 1'b1;
        edge_cnt++;
        clk_wait(8);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) xfer_bit(v[i]);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) xfer_bit(1'b0);
    endtask

    task automatic frame_start();
        mon_bits = 0;
        edge_cnt = 0;
        oe_seen  = 1'b0;
        ss = 1'b0;
        clk_wait(8);
    endtask

    task automatic frame_stop(input bit exp_fe);
        clk_wait(8);
        if (exp_fe) q_fe.push_back(1);
        ss = 1'b1;
        clk_wait(16);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({miso, miso_oe, cmd, cmd_valid, addr, addr_valid, rx_data,
                    rx_valid, tx_req, frame_end, busy});
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        clk_wait(4);
        #1;
        check("reset outputs", all_outs(), 64'h0);
        rst_n = 1'b1;
        clk_wait(16);

        // Read ID: two streamed bytes, no address.
        q_cmd.push_back(8'h9F);
        q_txreq.push_back(8); q_txreq.push_back(16); q_txreq.push_back(24);
        q_tx.push_back(8'hEF); q_tx.push_back(8'h40);
        q_miso.push_back(8'hEF); q_miso.push_back(8'h40);
        frame_start();
        send_byte(8'h9F);
        idle_bits(16);
        frame_stop(1'b1);

        // Page program: address then two received bytes.
        q_cmd.push_back(8'h02);
        q_addr.push_back(24'h012345);
        q_rx.push_back(8'hA5); q_rx.push_back(8'h5A);
        frame_start();
        send_byte(8'h02);
        check("busy in frame", 64'(busy), 64'h1);
        send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
        send_byte(8'hA5); send_byte(8'h5A);
        frame_stop(1'b1);
        check("miso_oe during write", 64'(oe_seen), 64'h0);
        check("busy after frame", 64'(busy), 64'h0);

        // Fast read with dummy cycles.
        q_cmd.push_back(8'h0B);
        q_addr.push_back(24'h000010);
        q_txreq.push_back(40); q_txreq.push_back(48);
        q_tx.push_back(8'h3C);
        q_miso.push_back(8'h3C);
        frame_start();
        send_byte(8'h0B);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        idle_bits(7);
        check("miso_oe during dummy", 64'(miso_oe), 64'h0);
        idle_bits(1);
        idle_bits(8);
        frame_stop(1'b1);

        // Abort inside the address phase, then a normal status read.
        q_cmd.push_back(8'h03);
        frame_start();
        send_byte(8'h03);
        idle_bits(5);
        frame_stop(1'b1);
        check("addr held after abort", 64'(addr), 64'h000010);
        q_cmd.push_back(8'h05);
        q_txreq.push_back(8); q_txreq.push_back(16);
        q_tx.push_back(8'h77);
        q_miso.push_back(8'h77);
        frame_start();
        send_byte(8'h05);
        idle_bits(8);
        frame_stop(1'b1);

        // Reset in the middle of a read; the remainder of that frame is ignored.
        q_cmd.push_back(8'h9F);
        q_txreq.push_back(8);
        q_tx.push_back(8'hA1);
        frame_start();
        send_byte(8'h9F);
        idle_bits(4);
        clk_wait(3);
        rst_n = 1'b0;
        #1;
        check("async reset outputs", all_outs(), 64'h0);
        clk_wait(3);
        rst_n = 1'b1;
        idle_bits(4);
        frame_stop(1'b0);
        q_cmd.push_back(8'h02);
        q_addr.push_back(24'hABCDEF);
        q_rx.push_back(8'h3C);
        frame_start();
        send_byte(8'h02);
        send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
        send_byte(8'h3C);
        frame_stop(1'b1);

        // Zero-length frame yields frame_end only.
        frame_start();
        frame_stop(1'b1);

`ifdef SPI_SL_QUAD_EN
        q_cmd.push_back(8'h6B);
        q_addr.push_back(24'h000000);
        q_txreq.push_back(40); q_txreq.push_back(42);
        q_tx.push_back(8'hC3);
        q_miso.push_back(8'hC3);
        frame_start();
        send_byte(8'h6B);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        idle_bits(8);
        idle_bits(1);
        check("dq_oe quad", 64'(dq_oe), 64'hF);
        idle_bits(1);
        frame_stop(1'b1);
        check("dq_oe after quad", 64'(dq_oe), 64'h0);
`endif

        clk_wait(20);
        check("leftover cmd", 64'(q_cmd.size()), 64'h0);
        check("leftover addr", 64'(q_addr.size()), 64'h0);
        check("leftover rx", 64'(q_rx.size()), 64'h0);
        check("leftover tx_req", 64'(q_txreq.size()), 64'h0);
        check("leftover miso", 64'(q_miso.size()), 64'h0);
        check("leftover frame_end", 64'(q_fe.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
